button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: pixel_clk and rst.
REQ-002 Parameter DEBOUNCE_CYCLES, default 360000, is the number of consecutive stable samples required (10 ms at 36 MHz); legal range 1 to 2^20-1.
REQ-003 Parameter REPEAT_DELAY, default 18000000, is the number of cycles from a press pulse to the first repeat pulse (0.5 s).
REQ-004 Parameter REPEAT_PERIOD, default 3600000, is the number of cycles between subsequent repeat pulses (0.1 s).
REQ-005 Port pixel_clk, input, 1 bit: 36 MHz pixel clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port btn_raw, input, 5 bits: raw, unsynchronised buttons, with bit 0 = C, bit 1 = U, bit 2 = D, bit 3 = R, bit 4 = L.
REQ-008 Port btn_level, output, 5 bits: debounced level of each button, registered.
REQ-009 Port btn_press, output, 5 bits: one-cycle pulse per debounced press, and per repeat when autorepeat is compiled in; registered; feeds the game button_c/u/d/r/l inputs.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each bit SHALL own an independent 20-bit debounce counter; bits never interact.
REQ-012 Debounce rule: on any edge where sync2 equals btn_level, the counter SHALL clear to 0.
REQ-013 Debounce rule: on an edge where sync2 differs from btn_level, the counter SHALL increment.
REQ-014 When the counter would reach DEBOUNCE_CYCLES, btn_level SHALL take sync2 and the counter SHALL clear, on that same edge.
REQ-015 Latency: if btn_raw changes and then holds, btn_level SHALL update on edge DEBOUNCE_CYCLES+2, where edge 1 is the first edge that samples the new value.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronised samples SHALL produce no change on btn_level or btn_press.
REQ-017 btn_press[i] SHALL be high for exactly one cycle, on the cycle in which btn_level[i] is first high after a 0-to-1 update.
REQ-018 A debounced release SHALL produce no pulse.
REQ-019 Simultaneous qualifying presses on several bits SHALL pulse in the same cycle.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES, and no wrap-around is permitted.

Reset
REQ-021 While rst is high, all synchronizers, counters, btn_level and btn_press SHALL be 0, asynchronously.
REQ-022 After rst deasserts with a button already held, the block SHALL treat it as a new press: btn_level rises on edge DEBOUNCE_CYCLES+2 and btn_press pulses once.
REQ-023 rst asserted mid-count or mid-repeat SHALL abort the operation immediately, with no pulse emitted.

Configuration
REQ-024 With macro BTN_AUTOREPEAT_EN defined, each bit SHALL own a 25-bit repeat counter that clears on the press pulse and counts while btn_level[i] is 1.
REQ-025 With BTN_AUTOREPEAT_EN defined, btn_press[i] SHALL pulse when that counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that, while the button is held.
REQ-026 With BTN_AUTOREPEAT_EN defined, a debounced release SHALL clear the repeat counter and stop repeats on the same edge.
REQ-027 Without BTN_AUTOREPEAT_EN, no repeat logic SHALL be synthesised, and exactly one pulse SHALL be emitted per debounced press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-028 Reset: rst=1 with btn_raw=5'h1F -> btn_level=0 and btn_press=0 throughout reset, and both outputs go 0 asynchronously.
REQ-029 Clean press: btn_raw[0] 0->1 and held -> btn_level[0]=1 at edge 6, btn_press=5'h01 for that single cycle only.
REQ-030 Glitch: btn_raw[3] high for 3 cycles, then low -> btn_level and btn_press stay 0.
REQ-031 Simultaneous press: btn_raw=5'h12 in one cycle -> btn_press=5'h12 for one cycle at edge 6; release -> no pulse.
REQ-032 Autorepeat (macro defined): hold U -> pulses at edge 6, then 10 and 15 cycles after that; releasing during a repeat interval -> no further pulses. Without the macro -> a single pulse.
REQ-033 Mid-operation reset: rst pulsed while the counter is at 3 -> no pulse; after rst deasserts with the button held -> press pulse 6 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: two-flop sync, per-bit debounce and press pulses for C/U/D/R/L.
// Define BTN_AUTOREPEAT_EN to add held-button autorepeat pulses.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 360000,
   parameter int unsigned REPEAT_DELAY    = 18000000,
   parameter int unsigned REPEAT_PERIOD   = 3600000
) (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic [4:0] btn_press
);
   localparam int unsigned NB = 5;
   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       REPEAT_DELAY + REPEAT_PERIOD > 33554431) begin : g_bad_param
      $error("button_conditioner: parameter out of range");
   end

   logic [NB-1:0] sync1;
   logic [NB-1:0] sync2;

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < NB; i++) begin : g_bit
      logic [19:0] cnt;
      logic        lvl_q;
      logic        press_q;
      logic        diff;
      logic        done;
      logic        rise;
      logic        pulse;

      assign diff = sync2[i] ^ lvl_q;
      // counter is about to reach DEBOUNCE_CYCLES on this edge
      assign done = diff && (cnt == DB_LAST);
      assign rise = done && sync2[i];

      always_ff @(posedge pixel_clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
         end else if (!diff || done) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end

      always_ff @(posedge pixel_clk or posedge rst) begin
         if (rst) begin
            lvl_q <= 1'b0;
         end else if (done) begin
            lvl_q <= sync2[i];
         end
      end

`ifdef BTN_AUTOREPEAT_EN
      localparam logic [24:0] RPT_FIRST = 25'(REPEAT_DELAY);
      localparam logic [24:0] RPT_WRAP  = 25'(REPEAT_DELAY + REPEAT_PERIOD);

      logic [24:0] rpt;
      logic [24:0] rpt_inc;
      logic        rpt_hit;

      assign rpt_inc = rpt + 25'd1;
      // once past the first repeat, fold back to REPEAT_DELAY every period
      assign rpt_hit = lvl_q && !done &&
                       ((rpt_inc == RPT_FIRST) || (rpt_inc == RPT_WRAP));

      always_ff @(posedge pixel_clk or posedge rst) begin
         if (rst) begin
            rpt <= '0;
         end else if (done || !lvl_q) begin
            rpt <= '0;
         end else if (rpt_inc == RPT_WRAP) begin
            rpt <= RPT_FIRST;
         end else begin
            rpt <= rpt_inc;
         end
      end

      assign pulse = rise || rpt_hit;
`else
      assign pulse = rise;
`endif

      always_ff @(posedge pixel_clk or posedge rst) begin
         if (rst) begin
            press_q <= 1'b0;
         end else begin
            press_q <= pulse;
         end
      end

      assign btn_level[i] = lvl_q;
      assign btn_press[i] = press_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5; follows BTN_AUTOREPEAT_EN like the RTL.
module tb_button_conditioner;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn_raw = '0;
   logic [4:0] btn_level;
   logic [4:0] btn_press;

   int total = 0;
   int bad = 0;

   // reference model state: sync pipeline, debounced level, run lengths, hold age
   logic [4:0] m_s1, m_s2, m_lvl, m_press;
   int run [5];
   int age [5];

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .pixel_clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      m_lvl = '0;
      m_press = '0;
      for (int i = 0; i < 5; i++) begin
         run[i] = 0;
         age[i] = 0;
      end
   endtask

   // one clock edge of behaviour, from values present before the edge
   task automatic model_step(input logic [4:0] raw);
      logic was;
      for (int i = 0; i < 5; i++) begin
         was = m_lvl[i];
         m_press[i] = 1'b0;
         if (m_s2[i] != m_lvl[i]) begin
            run[i]++;
            if (run[i] == DB) begin
               run[i] = 0;
               m_lvl[i] = m_s2[i];
               if (m_lvl[i]) begin
                  m_press[i] = 1'b1;
                  age[i] = 0;
               end
            end
         end else begin
            run[i] = 0;
         end
`ifdef BTN_AUTOREPEAT_EN
         if (was && m_lvl[i]) begin
            age[i]++;
            if (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0))
               m_press[i] = 1'b1;
         end
`else
         if (was && m_lvl[i]) age[i]++;
`endif
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   task automatic tick(input logic [4:0] raw);
      btn_raw = raw;
      @(posedge clk);
      if (rst) model_reset();
      else model_step(raw);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick(5'h00);
      tick(5'h00);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] el, ep;
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         tick(5'h1F);
         total++;
         if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
            $display("FAIL reset_hold k=%0d level=%h press=%h want 00/00",
                     k, btn_level, btn_press);
            bad++;
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick(5'h1F);
         el = (k >= 6) ? 5'h1F : 5'h00;
         ep = (k == 6) ? 5'h1F : 5'h00;
         total++;
         if (btn_level !== el || btn_press !== ep) begin
            $display("FAIL held_after_reset edge=%0d level=%h/%h press=%h/%h",
                     k, btn_level, el, btn_press, ep);
            bad++;
         end
      end
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      total++;
      if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
         $display("FAIL async_reset level=%h press=%h want 00/00",
                  btn_level, btn_press);
         bad++;
      end
      tick(5'h1F);
      rst = 1'b0;
   endtask

   task automatic test_clean_press();
      logic [4:0] el, ep;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         tick(5'h01);
         el = (k >= 6) ? 5'h01 : 5'h00;
         ep = (k == 6) ? 5'h01 : 5'h00;
         total++;
         if (btn_level !== el || btn_press !== ep) begin
            $display("FAIL clean_press edge=%0d level=%h/%h press=%h/%h",
                     k, btn_level, el, btn_press, ep);
            bad++;
         end
      end
      for (int k = 1; k <= 8; k++) begin
         tick(5'h00);
         el = (k >= 6) ? 5'h00 : 5'h01;
         total++;
         if (btn_level !== el || btn_press !== 5'h00) begin
            $display("FAIL clean_release edge=%0d level=%h/%h press=%h/00",
                     k, btn_level, el, btn_press);
            bad++;
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         tick((k <= 3) ? 5'h08 : 5'h00);
         total++;
         if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
            $display("FAIL glitch edge=%0d level=%h press=%h want 00/00",
                     k, btn_level, btn_press);
            bad++;
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] ep;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         tick(5'h12);
         ep = (k == 6) ? 5'h12 : 5'h00;
         total++;
         if (btn_press !== ep) begin
            $display("FAIL simul_press edge=%0d press=%h want %h", k, btn_press, ep);
            bad++;
         end
      end
      for (int k = 1; k <= 8; k++) begin
         tick(5'h00);
         total++;
         if (btn_press !== 5'h00) begin
            $display("FAIL simul_release edge=%0d press=%h want 00", k, btn_press);
            bad++;
         end
      end
      total++;
      if (btn_level !== 5'h00) begin
         $display("FAIL simul_level_after_release level=%h want 00", btn_level);
         bad++;
      end
   endtask

   task automatic test_autorepeat();
      logic [4:0] ep;
      do_reset();
      for (int k = 1; k <= 22; k++) begin
         tick(5'h02);
`ifdef BTN_AUTOREPEAT_EN
         ep = (k == 6 || k == 16 || k == 21) ? 5'h02 : 5'h00;
`else
         ep = (k == 6) ? 5'h02 : 5'h00;
`endif
         total++;
         if (btn_press !== ep) begin
            $display("FAIL repeat_hold edge=%0d press=%h want %h", k, btn_press, ep);
            bad++;
         end
      end
      for (int k = 23; k <= 35; k++) begin
         tick(5'h02);
         total++;
         if (btn_press !== m_press || btn_level !== m_lvl) begin
            $display("FAIL repeat_long edge=%0d level=%h/%h press=%h/%h",
                     k, btn_level, m_lvl, btn_press, m_press);
            bad++;
         end
      end
      for (int k = 1; k <= 25; k++) begin
         tick(5'h00);
         total++;
         if (btn_press !== m_press || btn_level !== m_lvl ||
             (k > 5 && btn_press !== 5'h00)) begin
            $display("FAIL repeat_release edge=%0d level=%h/%h press=%h/%h",
                     k, btn_level, m_lvl, btn_press, m_press);
            bad++;
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0] ep;
      do_reset();
      for (int k = 1; k <= 5; k++) tick(5'h04);
      rst = 1'b1;
      model_reset();
      #1;
      total++;
      if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
         $display("FAIL mid_reset_abort level=%h press=%h want 00/00",
                  btn_level, btn_press);
         bad++;
      end
      tick(5'h04);
      tick(5'h04);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick(5'h04);
         ep = (k == 6) ? 5'h04 : 5'h00;
         total++;
         if (btn_press !== ep) begin
            $display("FAIL mid_reset_repress edge=%0d press=%h want %h",
                     k, btn_press, ep);
            bad++;
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] v;
      int hold;
      do_reset();
      v = '0;
      for (int s = 0; s < 120; s++) begin
         v = v ^ 5'($urandom_range(0, 31));
         hold = $urandom_range(1, 9);
         for (int h = 0; h < hold; h++) begin
            tick(v);
            total++;
            if (btn_level !== m_lvl || btn_press !== m_press) begin
               $display("FAIL random seg=%0d level=%h/%h press=%h/%h",
                        s, btn_level, m_lvl, btn_press, m_press);
               bad++;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_glitch();
      test_simultaneous();
      test_autorepeat();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
